muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative RV32M/RV64M multiply/divide unit with valid/ready.
// Rev 1.0 -- optional MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              bypass_q, bypass_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;

  logic              accept, last;
  logic              sa_en, sb_en, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;
  logic              legal, div_zero, div_ovf;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, mul_fix;
  logic [XLEN-1:0]   div_sel, div_fix, mul_res;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;

  assign accept = in_valid && in_ready && !flush;
  assign last   = (cnt_q == CNT_W'(XLEN - 1));

  // op_a is signed for all but the *U ops; op_b only for MUL/MULH/DIV/REM
  assign sa_en = !(funct3[0] && (funct3[1] || funct3[2]));
  assign sb_en = funct3[2] ? !funct3[0] : !funct3[1];
  assign a_neg = sa_en && op_a[XLEN-1];
  assign b_neg = sb_en && op_b[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  assign legal    = (funct7 == 7'b0000001);
  assign div_zero = (op_b == '0);
  assign div_ovf  = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  always_comb begin
    special_res = '0;
    if (!legal)        special_res = '0;
    else if (div_zero) special_res = funct3[1] ? op_a : '1;
    else if (div_ovf)  special_res = funct3[1] ? '0 : op_a;
  end

  // Shift-add: accumulator high half gathers partial sums, low half holds multiplier
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;
  assign mul_res  = (f3_q == 3'b000) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];

  // Restoring divide: high half is the partial remainder, low half dividend/quotient
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
  assign div_sel   = f3_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
  assign div_fix   = neg_q ? -div_sel : div_sel;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{a_neg}}, op_a};
  assign fast_b    = {{XLEN{b_neg}}, op_b};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    bypass_d  = bypass_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_d      = funct3;
            illegal_d = !legal;
            cnt_d     = '0;
            bypass_d  = 1'b0;
            neg_d     = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            if (!legal || (funct3[2] && (div_zero || div_ovf))) begin
              // Single pass through DIV with the counter preset gives 1-edge latency
              state_d  = S_DIV;
              cnt_d    = CNT_W'(XLEN - 1);
              bypass_d = 1'b1;
              result_d = special_res;
            end else if (funct3[2]) begin
              state_d = S_DIV;
              opnd_d  = b_mag;
              acc_d   = {{XLEN{1'b0}}, a_mag};
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              state_d  = S_DIV;
              cnt_d    = CNT_W'(XLEN - 1);
              bypass_d = 1'b1;
              result_d = (funct3 == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
              state_d = S_MUL;
              opnd_d  = a_mag;
              acc_d   = {{XLEN{1'b0}}, b_mag};
`endif
            end
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            result_d = mul_res;
            state_d  = S_DONE;
          end
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            if (!bypass_q) result_d = div_fix;
            state_d = S_DONE;
          end
        end
        default: begin
          if (out_ready) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      bypass_q  <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      bypass_q  <= bypass_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit : directed self-checking bench for muldiv_unit (XLEN=32).
// Rev 1.0 -- latency expectations follow MULDIV_FAST_MUL_EN when defined.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;
  localparam int XLEN    = 32;
  localparam int DIV_LAT = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = 7'h01;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            illegal;

  int total = 0;
  int bad   = 0;
  int lat;
  int seen;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [6:0] f7,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 200);
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] exp_res, input logic exp_ill, input int exp_lat);
    int n;
    start_op(f3, f7, a, b);
    wait_valid(n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
    @(posedge clk);
    #1 check({tag, "_1wide"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    // reset state while rst_n is low
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // multiplies
    run("mul",    3'b000, 7'h01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, MUL_LAT);
    run("mulh",   3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, MUL_LAT);
    run("mulhsu", 3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, MUL_LAT);
    run("mulhu",  3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, MUL_LAT);

    // divides
    run("div",  3'b100, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    run("rem",  3'b110, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, DIV_LAT);
    run("divu", 3'b101, 7'h01, 32'd7,        32'd2, 32'd3,        1'b0, DIV_LAT);
    run("remu", 3'b111, 7'h01, 32'd7,        32'd2, 32'd1,        1'b0, DIV_LAT);

    // special cases
    run("divu0",  3'b101, 7'h01, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1);
    run("remu0",  3'b111, 7'h01, 32'd5,        32'd0,        32'd5,        1'b0, 1);
    run("divovf", 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    run("removf", 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);
    run("illeg",  3'b000, 7'h20, 32'd7,        32'd3,        32'd0,        1'b1, 1);

    // backpressure: result held, no new acceptance
    out_ready = 1'b0;
    start_op(3'b101, 7'h01, 32'd100, 32'd7);
    wait_valid(lat);
    check("bp_lat", lat, DIV_LAT);
    check("bp_res", result, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_res", result, 32'd14);
      check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 check("bp_no_accept", {31'b0, in_ready}, 32'd1);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 check("flush_idle_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("flush_idle_novalid", {31'b0, out_valid}, 32'd0);

    // flush at DIV iteration 10
    start_op(3'b100, 7'h01, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_div_ready", {31'b0, in_ready}, 32'd1);
    check("flush_div_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk) flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("flush_div_never_valid", seen, 32'd0);
    run("rem_after_flush", 3'b110, 7'h01, 32'd1000, 32'hFFFFFFFD, 32'd1, 1'b0, DIV_LAT);

    // asynchronous reset mid-multiply
    start_op(3'b000, 7'h01, 32'h00012345, 32'h00000100);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_illegal", {31'b0, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run("mul_after_rst", 3'b000, 7'h01, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0, MUL_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
